// File: rtl/mem_arbiter_pkg.sv
// Shared processor definitions for the instruction/data memory arbiter:
// FSM state encoding, requester port ids and default bus widths.
package mem_arbiter_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_BUSY_IF = 3'd1,
        ST_BUSY_D  = 3'd2,
        ST_ACK_IF  = 3'd3,
        ST_ACK_D   = 3'd4
    } state_t;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_D  = 1'b1
    } port_t;

    // Round-robin pick: on contention the port not granted last time wins.
    function automatic port_t pick_port(input logic if_req, input logic d_req, input port_t last);
        port_t sel;
        if (if_req && d_req) begin
            sel = (last == PORT_IF) ? PORT_D : PORT_IF;
        end else if (d_req) begin
            sel = PORT_D;
        end else begin
            sel = PORT_IF;
        end
        return sel;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the shared memory.
// The master view belongs to the arbiter, which masters the shared memory bus.
interface mem_arbiter_if
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ack;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        output if_rdata, if_ack, d_rdata, d_ack, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_ready,
        input  if_rdata, if_ack, d_rdata, d_ack, mem_req, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) round-robin arbiter in front of a single shared memory.
// One transaction at a time; every memory output and ack is driven from a register.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.master bus
);

    state_t            state_r;
    state_t            state_s;
    port_t             last_grant_r;
    port_t             grant_s;
    logic              start_s;
    logic              capture_s;

    logic              mem_req_r;
    logic              mem_we_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [DATA_W-1:0] mem_wdata_r;
    logic              if_ack_r;
    logic              d_ack_r;
    logic [DATA_W-1:0] if_rdata_r;
    logic [DATA_W-1:0] d_rdata_r;

    // Next-state logic; mem_ready only matters while a transaction is outstanding.
    always_comb begin
        state_s   = state_r;
        grant_s   = last_grant_r;
        start_s   = 1'b0;
        capture_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.if_req || bus.d_req) begin
                    start_s = 1'b1;
                    grant_s = pick_port(bus.if_req, bus.d_req, last_grant_r);
                    state_s = (grant_s == PORT_D) ? ST_BUSY_D : ST_BUSY_IF;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BUSY_IF: begin
                if (bus.mem_ready) begin
                    capture_s = 1'b1;
                    state_s   = ST_ACK_IF;
                end else begin
                    state_s   = ST_BUSY_IF;
                end
            end
            ST_BUSY_D: begin
                if (bus.mem_ready) begin
                    capture_s = 1'b1;
                    state_s   = ST_ACK_D;
                end else begin
                    state_s   = ST_BUSY_D;
                end
            end
            ST_ACK_IF: state_s = ST_IDLE;
            ST_ACK_D:  state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Grant, memory-request and completion registers; a reset mid-transaction drops it silently.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_r <= PORT_IF;
            mem_req_r    <= 1'b0;
            mem_we_r     <= 1'b0;
            mem_addr_r   <= {ADDR_W{1'b0}};
            mem_wdata_r  <= {DATA_W{1'b0}};
            if_ack_r     <= 1'b0;
            d_ack_r      <= 1'b0;
            if_rdata_r   <= {DATA_W{1'b0}};
            d_rdata_r    <= {DATA_W{1'b0}};
        end else begin
            if_ack_r <= (state_s == ST_ACK_IF);
            d_ack_r  <= (state_s == ST_ACK_D);
            if (start_s) begin
                mem_req_r    <= 1'b1;
                last_grant_r <= grant_s;
                if (grant_s == PORT_D) begin
                    mem_we_r    <= bus.d_we;
                    mem_addr_r  <= bus.d_addr;
                    mem_wdata_r <= bus.d_wdata;
                end else begin
                    mem_we_r    <= 1'b0;
                    mem_addr_r  <= bus.if_addr;
                    mem_wdata_r <= {DATA_W{1'b0}};
                end
            end else if (capture_s) begin
                mem_req_r <= 1'b0;
                if (state_r == ST_BUSY_IF) begin
                    if_rdata_r <= bus.mem_rdata;
                end else if (!mem_we_r) begin
                    d_rdata_r  <= bus.mem_rdata;
                end
            end
        end
    end

    assign bus.mem_req   = mem_req_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.if_ack    = if_ack_r;
    assign bus.d_ack     = d_ack_r;
    assign bus.if_rdata  = if_rdata_r;
    assign bus.d_rdata   = d_rdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized transaction-level bench for mem_arbiter: a word-addressed memory
// model and a round-robin grant model predict every grant, bus value and ack.
module tb_mem_arbiter;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference state: last winner (0 = fetch, 1 = data), delivered data, last bus values.
    bit          m_last;
    logic [31:0] m_i;
    logic [31:0] m_d;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    bit          m_we;
    logic [31:0] mem_m [logic [31:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // The two acks must never coincide.
    always @(negedge clk) begin
        if (!rst) begin
            check_eq("ack_excl", {63'd0, bus.if_ack & bus.d_ack}, 64'd0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        logic [31:0] v;
        if (mem_m.exists(a)) begin
            v = mem_m[a];
        end else begin
            v = 32'h5A00_0000 | a;
        end
        return v;
    endfunction

    task automatic model_reset();
        m_last  = 1'b0;
        m_i     = 32'd0;
        m_d     = 32'd0;
        m_addr  = 32'd0;
        m_wdata = 32'd0;
        m_we    = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_mem_req"},  {63'd0, bus.mem_req}, 64'd0);
        check_eq({tag, "_if_ack"},   {63'd0, bus.if_ack},  64'd0);
        check_eq({tag, "_d_ack"},    {63'd0, bus.d_ack},   64'd0);
        check_eq({tag, "_mem_we"},   {63'd0, bus.mem_we},  {63'd0, m_we});
        check_eq({tag, "_mem_addr"}, {32'd0, bus.mem_addr},  {32'd0, m_addr});
        check_eq({tag, "_mem_wd"},   {32'd0, bus.mem_wdata}, {32'd0, m_wdata});
        check_eq({tag, "_if_rdata"}, {32'd0, bus.if_rdata},  {32'd0, m_i});
        check_eq({tag, "_d_rdata"},  {32'd0, bus.d_rdata},   {32'd0, m_d});
    endtask

    // One arbitration round, entered and left at #1 after an edge in an IDLE cycle.
    task automatic txn(input bit w_if, input bit w_d, input bit we, input logic [31:0] a_if,
                       input logic [31:0] a_d, input logic [31:0] wd, input int lat, input bit drop);
        bit          g;
        logic [31:0] rd;
        bus.if_req  = w_if;
        bus.if_addr = a_if;
        bus.d_req   = w_d;
        bus.d_we    = we;
        bus.d_addr  = a_d;
        bus.d_wdata = wd;
        if (!w_if && !w_d) begin
            bus.mem_ready = ($urandom_range(0, 1) == 0);
            bus.mem_rdata = $urandom;
            tick();
            bus.mem_ready = 1'b0;
            check_quiet("idle");
            return;
        end
        g = (w_if && w_d) ? ~m_last : w_d;
        m_last  = g;
        m_addr  = g ? a_d : a_if;
        m_we    = g ? we : 1'b0;
        m_wdata = g ? wd : 32'd0;
        tick();
        check_eq("grant_req",  {63'd0, bus.mem_req}, 64'd1);
        check_eq("grant_we",   {63'd0, bus.mem_we},  {63'd0, m_we});
        check_eq("grant_addr", {32'd0, bus.mem_addr},  {32'd0, m_addr});
        check_eq("grant_wd",   {32'd0, bus.mem_wdata}, {32'd0, m_wdata});
        if (drop) begin
            if (g) bus.d_req = 1'b0;
            else   bus.if_req = 1'b0;
        end
        for (int i = 1; i < lat; i++) begin
            tick();
            check_eq("hold_req",  {63'd0, bus.mem_req}, 64'd1);
            check_eq("hold_addr", {32'd0, bus.mem_addr},  {32'd0, m_addr});
            check_eq("hold_wd",   {32'd0, bus.mem_wdata}, {32'd0, m_wdata});
            check_eq("hold_ack",  {62'd0, bus.if_ack, bus.d_ack}, 64'd0);
        end
        rd = (g && we) ? $urandom : mem_read(m_addr);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = rd;
        tick();
        bus.mem_ready = 1'b0;
        if (g && we) begin
            mem_m[m_addr] = wd;
        end else if (g) begin
            m_d = rd;
        end else begin
            m_i = rd;
        end
        check_eq("ack_if",   {63'd0, bus.if_ack}, {63'd0, ~g});
        check_eq("ack_d",    {63'd0, bus.d_ack},  {63'd0, g});
        check_eq("ack_req",  {63'd0, bus.mem_req}, 64'd0);
        check_eq("if_rdata", {32'd0, bus.if_rdata}, {32'd0, m_i});
        check_eq("d_rdata",  {32'd0, bus.d_rdata},  {32'd0, m_d});
        // A stray completion during the ack cycle must be ignored.
        bus.mem_ready = ($urandom_range(0, 1) == 0);
        bus.mem_rdata = $urandom;
        tick();
        bus.mem_ready = 1'b0;
        check_quiet("post_ack");
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        bus.if_req    = 1'b0;
        bus.if_addr   = 32'd0;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_addr    = 32'd0;
        bus.d_wdata   = 32'd0;
        bus.mem_rdata = 32'd0;
        bus.mem_ready = 1'b0;
        model_reset();
        repeat (2) tick();
        check_quiet("reset");
        rst = 1'b0;

        // Contention straight out of reset: data first, then strict alternation.
        for (int k = 0; k < 4; k++) begin
            txn(1'b1, 1'b1, 1'b0, 32'h40, 32'h44, 32'h0, 1, 1'b0);
            check_eq("rr_order", {63'd0, m_last}, {63'd0, ((k % 2) == 0)});
        end

        mem_m[32'h4]  = 32'h8C01_0000;
        txn(1'b1, 1'b0, 1'b0, 32'h4, 32'h0, 32'h0, 1, 1'b0);
        check_eq("fetch_data", {32'd0, bus.if_rdata}, {32'd0, 32'h8C01_0000});
        txn(1'b0, 1'b1, 1'b1, 32'h0, 32'h10, 32'hDEAD_BEEF, 3, 1'b0);
        mem_m[32'h20] = 32'h1234_5678;
        txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h20, 32'h0, 2, 1'b0);
        check_eq("load_data", {32'd0, bus.d_rdata}, {32'd0, 32'h1234_5678});
        txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h10, 32'h0, 1, 1'b1);
        check_eq("store_load", {32'd0, bus.d_rdata}, {32'd0, 32'hDEAD_BEEF});

        // Spurious completion with nothing outstanding.
        bus.if_req    = 1'b0;
        bus.d_req     = 1'b0;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hFFFF_FFFF;
        tick();
        bus.mem_ready = 1'b0;
        check_quiet("spurious");

        // Reset while a load is outstanding.
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h20;
        tick();
        check_eq("rst_busy_req", {63'd0, bus.mem_req}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check_eq("rst_async_req", {63'd0, bus.mem_req}, 64'd0);
        bus.d_req = 1'b0;
        model_reset();
        tick();
        rst           = 1'b0;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hBAD0_BAD0;
        tick();
        bus.mem_ready = 1'b0;
        check_quiet("rst_no_ack");
        tick();
        check_quiet("rst_idle");
        txn(1'b1, 1'b1, 1'b0, 32'h8, 32'h1C, 32'h0, 1, 1'b0);
        check_eq("rst_regrant_d", {63'd0, m_last}, 64'd1);

        // Randomized rounds, including dropped requests and variable latency.
        for (int r = 0; r < 200; r++) begin
            txn(($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0), ($urandom_range(0, 1) == 1),
                {27'd0, 3'($urandom_range(0, 7)), 2'b00}, {27'd0, 3'($urandom_range(0, 7)), 2'b00},
                $urandom, $urandom_range(1, 4), ($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
